// File: rtl/ttm4_rst_seq.sv
// Staggered reset sequencer: holds N_CH resets, then releases them one by one.
// Optional tick divider is enabled by defining TTM4_RST_SEQ_TICK_EN.
module ttm4_rst_seq #(
    parameter int N_CH     = 4,
    parameter int HOLD_CYC = 4,
    parameter int GAP_CYC  = 4,
    parameter int CNT_W    = 16,
    parameter int TICK_DIV = 50
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            SREQ,
    output logic [N_CH-1:0] RST_OUT,
    output logic            BUSY,
    output logic            DONE,
    output logic            TICK
);

    localparam int IDX_W = $clog2(N_CH) + 1;
    localparam int MAXV0 = (HOLD_CYC > GAP_CYC) ? HOLD_CYC : GAP_CYC;
    localparam int MAXV  = (MAXV0 > TICK_DIV) ? MAXV0 : TICK_DIV;

    generate
        if (N_CH < 1 || N_CH > 16) begin : g_bad_nch
            $error("ttm4_rst_seq: N_CH must be 1..16");
        end
        if (HOLD_CYC < 1 || GAP_CYC < 1) begin : g_bad_cyc
            $error("ttm4_rst_seq: HOLD_CYC and GAP_CYC must be >= 1");
        end
        if (TICK_DIV < 2) begin : g_bad_div
            $error("ttm4_rst_seq: TICK_DIV must be >= 2");
        end
        if (CNT_W < 1 || CNT_W > 31 || longint'(MAXV) > ((longint'(1) << CNT_W) - 1)) begin : g_bad_cntw
            $error("ttm4_rst_seq: CNT_W too small for HOLD_CYC/GAP_CYC/TICK_DIV");
        end
    endgenerate

    typedef enum logic [1:0] {S_HOLD, S_REL, S_DONE} state_t;

    state_t            state, state_n;
    logic [CNT_W-1:0]  cnt, cnt_n;
    logic [IDX_W-1:0]  idx, idx_n;
    logic              rel, restart;
    logic [N_CH-1:0]   rst_out_n;
    logic              busy_n, done_n;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state   <= S_HOLD;
            cnt     <= '0;
            idx     <= '0;
            RST_OUT <= '1;
            BUSY    <= 1'b1;
            DONE    <= 1'b0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            idx     <= idx_n;
            RST_OUT <= rst_out_n;
            BUSY    <= busy_n;
            DONE    <= done_n;
        end
    end

    // idx names the channel to release next; it is 0 throughout HOLD.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        idx_n   = idx;
        rel     = 1'b0;
        restart = 1'b0;
        if (RST || SREQ) begin
            restart = 1'b1;
            state_n = S_HOLD;
            cnt_n   = '0;
            idx_n   = '0;
        end else begin
            case (state)
                S_HOLD: begin
                    if (cnt == CNT_W'(HOLD_CYC - 1)) begin
                        rel     = 1'b1;
                        cnt_n   = '0;
                        idx_n   = IDX_W'(1);
                        state_n = (N_CH == 1) ? S_DONE : S_REL;
                    end else begin
                        cnt_n = cnt + 1'b1;
                    end
                end
                S_REL: begin
                    if (cnt == CNT_W'(GAP_CYC - 1)) begin
                        rel   = 1'b1;
                        cnt_n = '0;
                        idx_n = idx + 1'b1;
                        if (idx == IDX_W'(N_CH - 1))
                            state_n = S_DONE;
                    end else begin
                        cnt_n = cnt + 1'b1;
                    end
                end
                S_DONE: ;
                default: state_n = S_HOLD;
            endcase
        end
    end

    always_comb begin
        rst_out_n = RST_OUT;
        if (restart) begin
            rst_out_n = '1;
        end else if (rel) begin
            for (int k = 0; k < N_CH; k++)
                if (idx == IDX_W'(k))
                    rst_out_n[k] = 1'b0;
        end
        busy_n = |rst_out_n;
        done_n = (state_n == S_DONE);
    end

`ifdef TTM4_RST_SEQ_TICK_EN
    logic [CNT_W-1:0] tcnt;

    // Free-running; soft requests deliberately leave the divider alone.
    always_ff @(posedge CLK) begin
        if (RST) begin
            tcnt <= '0;
            TICK <= 1'b0;
        end else begin
            TICK <= (tcnt == CNT_W'(TICK_DIV - 1));
            tcnt <= (tcnt == CNT_W'(TICK_DIV - 1)) ? '0 : tcnt + 1'b1;
        end
    end
`else
    assign TICK = 1'b0;
`endif

endmodule

// File: tb/tb_ttm4_rst_seq.sv
// Scoreboard bench for ttm4_rst_seq: default 4-channel instance plus a 1-channel instance.
module tb_ttm4_rst_seq;

    localparam int H  = 4;
    localparam int G  = 4;
    localparam int N  = 4;
    localparam int TD = 50;
    localparam int H1 = 2;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       SREQ = 1'b0;
    logic [3:0] ro;
    logic       busy, done, tick;
    logic [0:0] ro1;
    logic       busy1, done1, tick1;

    always #5 CLK = ~CLK;

    ttm4_rst_seq u0 (
        .CLK(CLK), .RST(RST), .SREQ(SREQ),
        .RST_OUT(ro), .BUSY(busy), .DONE(done), .TICK(tick)
    );

    ttm4_rst_seq #(.N_CH(1), .HOLD_CYC(H1)) u1 (
        .CLK(CLK), .RST(RST), .SREQ(SREQ),
        .RST_OUT(ro1), .BUSY(busy1), .DONE(done1), .TICK(tick1)
    );

    typedef struct packed {
        logic [3:0] ro;
        logic       busy, done, tick;
        logic       ro1, busy1, done1, tick1;
    } exp_t;

    exp_t sb[$];
    exp_t mx;
    int   vectors = 0;
    int   miscompares = 0;
    int   e = 0;
    int   tk = 0;

    // Reference: e = edges since the last assertion, tk = edges since RST.
    task automatic step(input logic r, input logic s);
        exp_t x;
        RST  = r;
        SREQ = s;
        if (r || s) e = 0; else e++;
        if (r) tk = 0; else tk++;
        for (int k = 0; k < N; k++)
            x.ro[k] = (r || s) || (e < H + k * G);
        x.busy = |x.ro;
        x.done = !(r || s) && (e >= H + (N - 1) * G);
`ifdef TTM4_RST_SEQ_TICK_EN
        x.tick = !r && (tk % TD == 0);
`else
        x.tick = 1'b0;
`endif
        x.ro1   = (r || s) || (e < H1);
        x.busy1 = x.ro1;
        x.done1 = !x.ro1;
        x.tick1 = x.tick;
        sb.push_back(x);
        @(posedge CLK);
        #1;
    endtask

    always @(negedge CLK) begin
        if (sb.size() > 0) begin
            mx = sb.pop_front();
            vectors += 8;
            if (ro !== mx.ro)       begin miscompares++; $display("FAIL sb_rst_out t=%0t got %b exp %b", $time, ro, mx.ro); end
            if (busy !== mx.busy)   begin miscompares++; $display("FAIL sb_busy t=%0t got %b exp %b", $time, busy, mx.busy); end
            if (done !== mx.done)   begin miscompares++; $display("FAIL sb_done t=%0t got %b exp %b", $time, done, mx.done); end
            if (tick !== mx.tick)   begin miscompares++; $display("FAIL sb_tick t=%0t got %b exp %b", $time, tick, mx.tick); end
            if (ro1 !== mx.ro1)     begin miscompares++; $display("FAIL sb_n1_rst_out t=%0t got %b exp %b", $time, ro1, mx.ro1); end
            if (busy1 !== mx.busy1) begin miscompares++; $display("FAIL sb_n1_busy t=%0t got %b exp %b", $time, busy1, mx.busy1); end
            if (done1 !== mx.done1) begin miscompares++; $display("FAIL sb_n1_done t=%0t got %b exp %b", $time, done1, mx.done1); end
            if (tick1 !== mx.tick1) begin miscompares++; $display("FAIL sb_n1_tick t=%0t got %b exp %b", $time, tick1, mx.tick1); end
        end
    end

    task automatic test_reset();
        for (int n = 0; n < 4; n++) step(1'b1, 1'b0);
        vectors++;
        if ({ro, busy, done} !== 6'b1111_10) begin
            miscompares++;
            $display("FAIL reset_state got ro=%b busy=%b done=%b exp 1111/1/0", ro, busy, done);
        end
    endtask

    task automatic test_sequence();
        logic [3:0] want;
        for (int n = 1; n <= 18; n++) begin
            step(1'b0, 1'b0);
            want = (n < 4) ? 4'b1111 : (n < 8) ? 4'b1110 : (n < 12) ? 4'b1100 :
                   (n < 16) ? 4'b1000 : 4'b0000;
            vectors++;
            if (ro !== want) begin
                miscompares++;
                $display("FAIL seq_edge%0d got %b exp %b", n, ro, want);
            end
            if (n <= 2) begin
                vectors++;
                if (ro1 !== (n < 2 ? 1'b1 : 1'b0) || done1 !== (n == 2)) begin
                    miscompares++;
                    $display("FAIL n1_edge%0d got ro=%b done=%b", n, ro1, done1);
                end
            end
        end
        vectors++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL seq_done got done=%b busy=%b exp 1/0", done, busy);
        end
    endtask

    task automatic test_sreq();
        step(1'b0, 1'b1);
        vectors++;
        if ({ro, busy, done} !== 6'b1111_10) begin
            miscompares++;
            $display("FAIL sreq_assert got ro=%b busy=%b done=%b exp 1111/1/0", ro, busy, done);
        end
        for (int n = 1; n <= 16; n++) begin
            step(1'b0, 1'b0);
            if (n == 3 || n == 4 || n == 16) begin
                vectors++;
                if (ro !== (n == 3 ? 4'b1111 : n == 4 ? 4'b1110 : 4'b0000)) begin
                    miscompares++;
                    $display("FAIL sreq_edge%0d got %b", n, ro);
                end
            end
        end
    endtask

    task automatic test_mid_reset();
        step(1'b1, 1'b0);
        for (int n = 1; n <= 10; n++) step(1'b0, 1'b0);
        vectors++;
        if (ro !== 4'b1100) begin miscompares++; $display("FAIL mid_edge10 got %b exp 1100", ro); end
        step(1'b1, 1'b0);
        vectors++;
        if (ro !== 4'b1111) begin miscompares++; $display("FAIL mid_rerst got %b exp 1111", ro); end
        for (int n = 1; n <= 16; n++) step(1'b0, 1'b0);
        vectors++;
        if (ro !== 4'b0000 || done !== 1'b1) begin
            miscompares++;
            $display("FAIL mid_rerun got ro=%b done=%b exp 0000/1", ro, done);
        end
    endtask

    task automatic test_both();
        step(1'b1, 1'b1);
        step(1'b1, 1'b1);
        for (int n = 0; n < 3; n++) step(1'b0, 1'b1);
        for (int n = 1; n <= 4; n++) begin
            step(1'b0, 1'b0);
            vectors++;
            if (ro !== (n < 4 ? 4'b1111 : 4'b1110)) begin
                miscompares++;
                $display("FAIL both_edge%0d got %b", n, ro);
            end
        end
    endtask

    task automatic test_tick();
        step(1'b1, 1'b0);
        for (int n = 1; n <= 1000; n++) begin
            step(1'b0, n == 75);
`ifdef TTM4_RST_SEQ_TICK_EN
            if (n == 99 || n == 100 || n == 101 || n == 150) begin
                vectors++;
                if (tick !== (n == 100 || n == 150)) begin
                    miscompares++;
                    $display("FAIL tick_edge%0d got %b", n, tick);
                end
            end
`else
            vectors++;
            if (tick !== 1'b0) begin
                miscompares++;
                $display("FAIL tick_off_edge%0d got %b exp 0", n, tick);
            end
`endif
        end
    endtask

    initial begin
        test_reset();
        test_sequence();
        test_sreq();
        test_mid_reset();
        test_both();
        test_tick();
        @(negedge CLK);
        #1;
        vectors++;
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL sb_drain got %0d left exp 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
